// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller that drives npc, issues imem fetches and buffers the returned word
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] REQ  = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;
  logic [1:0]  state, state_n;
  logic        rp, redir, take;
  logic [31:0] rt, tgt;
  assign tgt         = {redirect_target[31:2], 2'b00};
  assign imem_addr   = pc;
  assign imem_req    = state[0];
  assign instr_valid = state[1];
  assign redir       = imem_ack & (rp | redirect_valid);
  assign take        = state == REQ && imem_ack && !(rp || redirect_valid);
  // next state and next pc; a discarded ack stays in REQ and refetches from the redirect target
  always_comb begin
    state_n = state == IDLE ? REQ :
              state == REQ  ? (take ? HOLD : REQ) :
              (redirect_valid || instr_ready) ? REQ : HOLD;
    npc     = !reset ? RESET_PC :
              state == REQ ? (redir ? (redirect_valid ? tgt : rt) : pc) :
              redirect_valid ? tgt :
              (state == HOLD && instr_ready) ? pc + 32'd4 : pc;
  end
  // state, instruction buffer and pending-redirect bookkeeping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      instr <= '0;
      rp    <= 1'b0;
      rt    <= '0;
    end else begin
      state <= state_n;
      if (take) instr <= imem_rdata;
      if (state == REQ) rp <= ~imem_ack & (rp | redirect_valid);
      if (state == REQ && redirect_valid && !imem_ack) rt <= tgt;
    end
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller for the single-cycle processor. It is the consumer of the program counter register: it reads `pc`, issues the fetch to instruction memory over a req/ack handshake, and buffers the returned word for the core. It drives `npc` back into the program counter register: it holds `pc` while a fetch is outstanding, advances by 4 when the core accepts, and loads a redirect target on branch or jump.

## Interface
- `RESET_PC`, default 32'h0000_3000: reset value of the program counter register. Used only for checking: `npc` equals it while `pc` is in reset.
- `clock`  in  1  clock; rising edge active
- `reset`  in  1  reset, asynchronous, active-low
- `pc`  in  32  current instruction address from the program counter register
- `npc`  out  32  next instruction address to the program counter register (combinational)
- `imem_addr`  out  32  fetch address; equals `pc` (combinational)
- `imem_req`  out  1  fetch request (registered); held until `imem_ack`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle; meaningful only while `imem_req`=1
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  buffered instruction (registered)
- `instr_valid`  out  1  `instr` is valid (registered)
- `instr_ready`  in  1  core accepts `instr` this cycle
- `redirect_valid`  in  1  single-cycle branch/jump request
- `redirect_target`  in  32  new address; bits [1:0] are forced to 0

## Operation
- States: IDLE, REQ, HOLD. There is also a pending-redirect flag `rp` and a 32-bit register `rt`.
- Reset (async, any state): state=IDLE; `imem_req`=0, `instr_valid`=0, `instr`=0, `rp`=0, `rt`=0.
- IDLE:
  - The first rising edge with reset high moves to REQ, with `npc`=`pc`.
  - `redirect_valid` in IDLE: `npc`=target and go to REQ.
  - `imem_ack` is ignored in IDLE.
- REQ: `imem_req`=1 and `imem_addr`=`pc`. `pc` must not change until ack, so `npc`=`pc`.
  - `imem_ack` with no redirect active (`rp`=0, `redirect_valid`=0): `instr`<=`imem_rdata`, `instr_valid`<=1, `imem_req`<=0, go to HOLD.
  - `redirect_valid` without ack: `rp`<=1 and `rt`<=target. A later redirect overwrites `rt` (latest wins).
  - `imem_ack` with `rp`=1 or `redirect_valid`=1: discard the data and set `npc` to the target (`redirect_target` if `redirect_valid`, else `rt`). Clear `rp`, stay in REQ (`imem_req` stays 1), and the new address takes effect the next cycle.
- HOLD: `imem_req`=0, `instr_valid`=1.
  - `redirect_valid` (takes priority over `instr_ready`): `instr_valid`<=0, `npc`=target, go to REQ.
  - `instr_ready` with no redirect: `npc`=`pc`+4, `instr_valid`<=0, go to REQ.
  - Otherwise: `npc`=`pc` and `instr` is stable.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. Redirect targets have bits [1:0] cleared.

## Timing
- `npc` is combinational from state, `pc` and the inputs. The program counter register captures it on the same edge that changes state.
- Fetch latency: `imem_req` rises 1 cycle after reset release. With same-cycle ack, `instr_valid` rises on the next edge.
- Peak throughput is 1 instruction per 2 cycles (REQ with immediate ack, then HOLD with `instr_ready`).
- Memory rule: `imem_addr` is stable whenever `imem_req`=1 and no ack is seen. A back-to-back request after a discarded ack is legal.
- Reset asserted mid-fetch abandons the request: `imem_req` drops asynchronously and a late `imem_ack` is ignored.

## Test plan
- Reset, then release with `pc`=0x3000 and ack on the 2nd REQ cycle with rdata=0x2001_0005. Required:
  - `imem_req` rises 1 cycle after release and `imem_addr`=0x3000.
  - `instr`=0x2001_0005 and `instr_valid`=1 on the edge after ack.
  - `npc`=0x3000 until `instr_ready`, then 0x3004.
- Streaming with ack and `instr_ready` tied to 1: addresses 0x3000, 0x3004, 0x3008 are fetched on alternating cycles; each `instr` is held exactly 1 cycle.
- Redirect in HOLD with target 0x0000_3043 and `instr_ready`=1: `instr_valid` drops, `npc`=0x3040, and the next `imem_addr` is 0x3040, not 0x3004.
- Redirect 0x4000 during REQ, then 0x5000, then ack 3 cycles later: `imem_addr` stays at 0x3000 until ack, the ack data is discarded (`instr_valid` stays 0), and the next `imem_addr` is 0x5000.
- `pc`=0xFFFF_FFFC, ack, then `instr_ready`: `npc`=0x0000_0000.
- Reset pulse while `imem_req`=1, with ack arriving 1 cycle after release: `imem_req`=0 and `instr_valid`=0 immediately, the ack is ignored in IDLE, and a normal fetch then follows.
